hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning the number of busy cycles of a multiply started in EX.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning the number of busy cycles of a divide started in EX; DIV_CYCLES >= MULT_CYCLES >= 1.
REQ-003 SHALL have parameter CNT_W, default 32, meaning the width of the stall-cycle performance counter.
REQ-004 Ports, one per line (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- RsD, RtD, RsE, RtE  in  5 each  source register numbers in ID/EX.
- RegAddrE, RegAddrM, RegAddrW  in  5 each  destination register numbers.
- RegWriteE, RegWriteM, RegWriteW  in  1 each  destination write enables.
- MemtoRegE, MemtoRegM, cpztoRegE, cpztoRegM  in  1 each  late-result (load / MFC0) producers.
- EarlyUseD  in  1  ID instruction consumes Rs/Rt in ID (branch compare or jump-register).
- MDUStartE  in  1  mult/div issued in EX this cycle.
- MDUIsDivE  in  1  qualifies MDUStartE as a divide.
- MDUUseD  in  1  ID instruction is mult/div/MTHI/MTLO/MFHI/MFLO.
- cpzWriteE  in  1  MTC0 in EX.
- ERETD  in  1  ERET in ID.
- ExcHandle  in  1  exception taken in MEM.
- StallCntClr  in  1  synchronous clear of the stall counter.
- Forward_A_D, Forward_B_D, Forward_A_E, Forward_B_E  out  2 each  operand-forwarding select.
- Forward_EPC  out  1  EPC bypass from the MTC0 in EX.
- pc_Exc, pc_ERET  out  1 each  NPC selects.
- Stall_PC, Stall_IF_ID, Stall_ID_EX, Stall_EX_MEM, Stall_MEM_WB  out  1 each  register holds.
- Flush_IF_ID, Flush_ID_EX, Flush_EX_MEM, Flush_MEM_WB  out  1 each  register clears.
- MDUBusy  out  1  MDU busy indicator.
- MDUCLR  out  1  abort pulse to the MDU.
- StallCnt  out  CNT_W  saturating count of stalled cycles.

Function
REQ-005 Forward selects SHALL be combinational: register 0 -> NONE; else RegWriteM and address match -> from MEM; else RegWriteW and address match -> from WB; else NONE (MEM wins over WB).
REQ-006 Load-use stall SHALL assert when (MemtoRegE|cpztoRegE) and RegAddrE != 0 and RegAddrE equals RsD or RtD.
REQ-007 Early-use stall SHALL assert when EarlyUseD and either (RegWriteE, RegAddrE != 0, matches RsD/RtD) or ((MemtoRegM|cpztoRegM), RegAddrM != 0, matches RsD/RtD).
REQ-008 The MDU counter SHALL load MULT_CYCLES, or DIV_CYCLES when MDUIsDivE, on a clock edge with MDUStartE=1 and ExcHandle=0, decrement each later cycle while nonzero, and hold at 0.
REQ-009 MDUBusy SHALL equal (counter != 0) OR MDUStartE.
REQ-010 MDU stall SHALL assert when MDUBusy and MDUUseD; a multiply issued at edge N releases a dependent ID instruction in the cycle after edge N+MULT_CYCLES.
REQ-011 Stall_PC = Stall_IF_ID = (any of REQ-006/007/010) AND NOT ExcHandle.
REQ-012 Flush_ID_EX SHALL be 1 for any stall or ExcHandle; Flush_EX_MEM = Flush_MEM_WB = ExcHandle; Stall_ID_EX, Stall_EX_MEM, Stall_MEM_WB, Flush_IF_ID are constant 0.
REQ-013 ExcHandle SHALL force the counter to 0 at the next edge, overriding a simultaneous MDUStartE.
REQ-014 MDUCLR SHALL be combinational: ExcHandle AND MDUBusy.
REQ-015 Forward_EPC = cpzWriteE AND RegAddrE == EPC_ID; pc_ERET = ERETD; pc_Exc = ExcHandle.
REQ-016 StallCnt SHALL increment by 1 each edge with Stall_PC=1 and saturate at all-ones.
REQ-017 StallCntClr SHALL zero StallCnt at the next edge and take priority over increment.

Reset
REQ-018 reset SHALL asynchronously zero the MDU counter and StallCnt; during reset MDUBusy = MDUStartE and all stall/flush outputs follow the combinational rules.

Structure
REQ-019 Forward encodings (NONE=00, MEM=01, WB=10), EPC_ID (14) and default cycle counts SHALL live in the shared macro header.
REQ-020 The MDU busy counter SHALL be a sub-module, mdu_busy_tracker; everything else is flat.

Verification
REQ-021 Scenario: lw $8 in EX, addu using $8 in ID -> Stall_PC=1 and Flush_ID_EX=1 for one cycle, then Forward_A_E=01.
REQ-022 Scenario: RegWriteM=RegWriteW=1, RegAddrM=RegAddrW=5, RsE=5 -> Forward_A_E=01; with RsE=0 -> Forward_A_E=00.
REQ-023 Scenario: mult issued (MULT_CYCLES=5), mflo in ID -> exactly 5 stall cycles, StallCnt=5.
REQ-024 Scenario: div issued, ExcHandle on the 3rd busy cycle -> MDUCLR=1, Flush_EX_MEM=1, Stall_PC=0, MDUBusy=0 on the next cycle.
REQ-025 Scenario: MTC0 to register 14 in EX with ERETD=1 -> Forward_EPC=1, pc_ERET=1, no stall.
REQ-026 Scenario: StallCnt forced to all-ones while stalling -> stays all-ones; StallCntClr=1 with stall -> 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the hazard controller: forward-select encodings,
// the CP0 EPC register number and default MDU latencies.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  localparam logic [4:0] EPC_ID = 5'd14;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // $0 is never forwarded; a MEM-stage producer is younger than WB and wins.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] dst_m,
                                         input logic [4:0] dst_w,
                                         input logic       wr_m,
                                         input logic       wr_w);
    logic [1:0] sel;
    sel = FWD_NONE;
    if (src != 5'd0) begin
      if (wr_m && (src == dst_m))      sel = FWD_MEM;
      else if (wr_w && (src == dst_w)) sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mdu_busy_tracker.sv
// Counts down the remaining busy cycles of a multiply/divide issued in EX;
// an exception in MEM aborts the operation and wins over a new issue.
module mdu_busy_tracker
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  input  logic exc,
  output logic busy
);

  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           cnt <= '0;
    else if (exc)        cnt <= '0;
    else if (start)      cnt <= is_div ? DIV_LD : MULT_LD;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  // The issuing cycle already counts as busy so a dependent op in ID stalls.
  assign busy = (cnt != '0) | start;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load/early-use/MDU stalls,
// exception flushes, EPC bypass and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       RegAddrE,
  input  logic [4:0]       RegAddrM,
  input  logic [4:0]       RegAddrW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             cpztoRegE,
  input  logic             cpztoRegM,
  input  logic             EarlyUseD,
  input  logic             MDUStartE,
  input  logic             MDUIsDivE,
  input  logic             MDUUseD,
  input  logic             cpzWriteE,
  input  logic             ERETD,
  input  logic             ExcHandle,
  input  logic             StallCntClr,
  output logic [1:0]       Forward_A_D,
  output logic [1:0]       Forward_B_D,
  output logic [1:0]       Forward_A_E,
  output logic [1:0]       Forward_B_E,
  output logic             Forward_EPC,
  output logic             pc_Exc,
  output logic             pc_ERET,
  output logic             Stall_PC,
  output logic             Stall_IF_ID,
  output logic             Stall_ID_EX,
  output logic             Stall_EX_MEM,
  output logic             Stall_MEM_WB,
  output logic             Flush_IF_ID,
  output logic             Flush_ID_EX,
  output logic             Flush_EX_MEM,
  output logic             Flush_MEM_WB,
  output logic             MDUBusy,
  output logic             MDUCLR,
  output logic [CNT_W-1:0] StallCnt
);

  logic src_hit_e, src_hit_m;
  logic load_use_stall, early_use_stall, mdu_stall, any_stall;

  assign Forward_A_D = fwd_sel(RsD, RegAddrM, RegAddrW, RegWriteM, RegWriteW);
  assign Forward_B_D = fwd_sel(RtD, RegAddrM, RegAddrW, RegWriteM, RegWriteW);
  assign Forward_A_E = fwd_sel(RsE, RegAddrM, RegAddrW, RegWriteM, RegWriteW);
  assign Forward_B_E = fwd_sel(RtE, RegAddrM, RegAddrW, RegWriteM, RegWriteW);

  assign src_hit_e = (RegAddrE != 5'd0) && ((RegAddrE == RsD) || (RegAddrE == RtD));
  assign src_hit_m = (RegAddrM != 5'd0) && ((RegAddrM == RsD) || (RegAddrM == RtD));

  // Late results (load, MFC0) cannot be forwarded into EX from EX itself.
  assign load_use_stall  = (MemtoRegE | cpztoRegE) && src_hit_e;
  // Branch/JR compare in ID needs the value one stage earlier than EX does.
  assign early_use_stall = EarlyUseD &&
                           ((RegWriteE && src_hit_e) ||
                            ((MemtoRegM | cpztoRegM) && src_hit_m));

  mdu_busy_tracker #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_mdu_busy (
    .clk   (clk),
    .reset (reset),
    .start (MDUStartE),
    .is_div(MDUIsDivE),
    .exc   (ExcHandle),
    .busy  (MDUBusy)
  );

  assign mdu_stall = MDUBusy && MDUUseD;
  assign any_stall = load_use_stall | early_use_stall | mdu_stall;

  assign Stall_PC     = any_stall && !ExcHandle;
  assign Stall_IF_ID  = Stall_PC;
  assign Stall_ID_EX  = 1'b0;
  assign Stall_EX_MEM = 1'b0;
  assign Stall_MEM_WB = 1'b0;

  assign Flush_IF_ID  = 1'b0;
  assign Flush_ID_EX  = any_stall | ExcHandle;
  assign Flush_EX_MEM = ExcHandle;
  assign Flush_MEM_WB = ExcHandle;

  assign MDUCLR      = ExcHandle && MDUBusy;
  assign Forward_EPC = cpzWriteE && (RegAddrE == EPC_ID);
  assign pc_ERET     = ERETD;
  assign pc_Exc      = ExcHandle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         StallCnt <= '0;
    else if (StallCntClr)              StallCnt <= '0;
    else if (Stall_PC && ~&StallCnt)   StallCnt <= StallCnt + 1'b1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a cycle-level model
// that tracks MDU occupancy as an end-cycle index and stalls as an integer.
module tb_hazard_ctrl;

  localparam int MULT = 5;
  localparam int DIV  = 10;
  localparam int CW   = 4;
  localparam int SAT  = (1 << CW) - 1;

  logic clk, reset;
  logic [4:0] RsD, RtD, RsE, RtE, RegAddrE, RegAddrM, RegAddrW;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, cpztoRegE, cpztoRegM;
  logic EarlyUseD, MDUStartE, MDUIsDivE, MDUUseD, cpzWriteE, ERETD, ExcHandle, StallCntClr;
  logic [1:0] Forward_A_D, Forward_B_D, Forward_A_E, Forward_B_E;
  logic Forward_EPC, pc_Exc, pc_ERET;
  logic Stall_PC, Stall_IF_ID, Stall_ID_EX, Stall_EX_MEM, Stall_MEM_WB;
  logic Flush_IF_ID, Flush_ID_EX, Flush_EX_MEM, Flush_MEM_WB;
  logic MDUBusy, MDUCLR;
  logic [CW-1:0] StallCnt;

  hazard_ctrl #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIV), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .RegAddrE(RegAddrE), .RegAddrM(RegAddrM), .RegAddrW(RegAddrW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .cpztoRegE(cpztoRegE), .cpztoRegM(cpztoRegM),
    .EarlyUseD(EarlyUseD), .MDUStartE(MDUStartE), .MDUIsDivE(MDUIsDivE), .MDUUseD(MDUUseD),
    .cpzWriteE(cpzWriteE), .ERETD(ERETD), .ExcHandle(ExcHandle), .StallCntClr(StallCntClr),
    .Forward_A_D(Forward_A_D), .Forward_B_D(Forward_B_D),
    .Forward_A_E(Forward_A_E), .Forward_B_E(Forward_B_E),
    .Forward_EPC(Forward_EPC), .pc_Exc(pc_Exc), .pc_ERET(pc_ERET),
    .Stall_PC(Stall_PC), .Stall_IF_ID(Stall_IF_ID), .Stall_ID_EX(Stall_ID_EX),
    .Stall_EX_MEM(Stall_EX_MEM), .Stall_MEM_WB(Stall_MEM_WB),
    .Flush_IF_ID(Flush_IF_ID), .Flush_ID_EX(Flush_ID_EX),
    .Flush_EX_MEM(Flush_EX_MEM), .Flush_MEM_WB(Flush_MEM_WB),
    .MDUBusy(MDUBusy), .MDUCLR(MDUCLR), .StallCnt(StallCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state: number of edges seen, edge index at which the MDU goes idle,
  // and the stall count as a plain integer.
  int edges = 0;
  int busy_end = 0;
  int sc = 0;
  logic m_stall_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (src == 0) return 2'd0;
    if (RegWriteM && src == RegAddrM) return 2'd1;
    if (RegWriteW && src == RegAddrW) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_check();
    logic lu, eu, busy, ms, any;
    lu   = (MemtoRegE || cpztoRegE) && RegAddrE != 0 && (RegAddrE == RsD || RegAddrE == RtD);
    eu   = EarlyUseD &&
           ((RegWriteE && RegAddrE != 0 && (RegAddrE == RsD || RegAddrE == RtD)) ||
            ((MemtoRegM || cpztoRegM) && RegAddrM != 0 && (RegAddrM == RsD || RegAddrM == RtD)));
    busy = (edges < busy_end) || MDUStartE;
    ms   = busy && MDUUseD;
    any  = lu || eu || ms;
    m_stall_pc = any && !ExcHandle;
    chk("fwd_a_d", Forward_A_D, m_fwd(RsD));
    chk("fwd_b_d", Forward_B_D, m_fwd(RtD));
    chk("fwd_a_e", Forward_A_E, m_fwd(RsE));
    chk("fwd_b_e", Forward_B_E, m_fwd(RtE));
    chk("fwd_epc", Forward_EPC, cpzWriteE && RegAddrE == 14);
    chk("pc_eret", pc_ERET, ERETD);
    chk("pc_exc", pc_Exc, ExcHandle);
    chk("stall_pc", Stall_PC, m_stall_pc);
    chk("stall_if_id", Stall_IF_ID, m_stall_pc);
    chk("flush_id_ex", Flush_ID_EX, any || ExcHandle);
    chk("flush_ex_mem", Flush_EX_MEM, ExcHandle);
    chk("flush_mem_wb", Flush_MEM_WB, ExcHandle);
    chk("const_zero", {Stall_ID_EX, Stall_EX_MEM, Stall_MEM_WB, Flush_IF_ID}, 4'd0);
    chk("mdu_busy", MDUBusy, busy);
    chk("mduclr", MDUCLR, ExcHandle && busy);
    chk("stall_cnt", StallCnt, sc);
  endtask

  task automatic settle();
    @(negedge clk);
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    edges++;
    if (reset) begin
      busy_end = 0;
      sc = 0;
    end else begin
      if (ExcHandle)      busy_end = 0;
      else if (MDUStartE) busy_end = edges + (MDUIsDivE ? DIV : MULT);
      if (StallCntClr)    sc = 0;
      else if (m_stall_pc && sc < SAT) sc++;
    end
    #1;
  endtask

  task automatic idle();
    {RsD, RtD, RsE, RtE, RegAddrE, RegAddrM, RegAddrW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, cpztoRegE, cpztoRegM} = '0;
    {EarlyUseD, MDUStartE, MDUIsDivE, MDUUseD, cpzWriteE, ERETD, ExcHandle, StallCntClr} = '0;
  endtask

  task automatic rand_inputs();
    RsD = 5'($urandom_range(0, 3));  RtD = 5'($urandom_range(0, 3));
    RsE = 5'($urandom_range(0, 3));  RtE = 5'($urandom_range(0, 3));
    RegAddrE = 5'($urandom_range(0, 3));
    RegAddrM = 5'($urandom_range(0, 3));
    RegAddrW = 5'($urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) RegAddrE = 5'd14;
    {RegWriteE, RegWriteM, RegWriteW} = 3'($urandom);
    MemtoRegE = ($urandom_range(0, 3) == 0);
    MemtoRegM = ($urandom_range(0, 3) == 0);
    cpztoRegE = ($urandom_range(0, 7) == 0);
    cpztoRegM = ($urandom_range(0, 7) == 0);
    EarlyUseD = ($urandom_range(0, 3) == 0);
    MDUStartE = ($urandom_range(0, 7) == 0);
    MDUIsDivE = 1'($urandom);
    MDUUseD   = ($urandom_range(0, 2) == 0);
    cpzWriteE = ($urandom_range(0, 3) == 0);
    ERETD     = ($urandom_range(0, 7) == 0);
    ExcHandle = ($urandom_range(0, 15) == 0);
    StallCntClr = ($urandom_range(0, 31) == 0);
  endtask

  initial begin
    int n;
    idle();
    reset = 1'b1;
    #2;
    chk("reset_cnt", StallCnt, 0);
    chk("reset_busy", MDUBusy, 0);
    settle(); tick();
    reset = 1'b0;

    // Load-use: lw $8 in EX, addu $8 in ID, then addu in EX with lw in MEM.
    idle(); MemtoRegE = 1; RegWriteE = 1; RegAddrE = 5'd8; RsD = 5'd8;
    settle();
    chk("lu_stall", Stall_PC, 1);
    chk("lu_flush", Flush_ID_EX, 1);
    tick();
    idle(); RegWriteM = 1; MemtoRegM = 1; RegAddrM = 5'd8; RsE = 5'd8;
    settle();
    chk("lu_release", Stall_PC, 0);
    chk("lu_fwd_mem", Forward_A_E, 2'b01);
    tick();

    // MEM beats WB; $0 never forwarded.
    idle(); RegWriteM = 1; RegWriteW = 1; RegAddrM = 5'd5; RegAddrW = 5'd5; RsE = 5'd5;
    settle();
    chk("fwd_mem_wins", Forward_A_E, 2'b01);
    RsE = 5'd0;
    settle();
    chk("fwd_zero", Forward_A_E, 2'b00);
    RegWriteM = 0; RsE = 5'd5;
    settle();
    chk("fwd_wb", Forward_A_E, 2'b10);
    tick();

    // mult issued, mflo waits in ID: exactly MULT stall cycles.
    idle(); MDUStartE = 1; StallCntClr = 1;
    settle(); tick();
    idle(); MDUUseD = 1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      settle();
      if (!Stall_PC) break;
      n++;
      tick();
    end
    chk("mult_stalls", n, MULT);
    chk("mult_stallcnt", StallCnt, MULT);
    tick();

    // div aborted by an exception on its 3rd busy cycle.
    idle(); MDUStartE = 1; MDUIsDivE = 1;
    settle(); tick();
    idle();
    settle(); tick();
    ExcHandle = 1; MDUUseD = 1;
    settle();
    chk("exc_mduclr", MDUCLR, 1);
    chk("exc_flush_em", Flush_EX_MEM, 1);
    chk("exc_stall_pc", Stall_PC, 0);
    tick();
    idle();
    settle();
    chk("exc_busy_off", MDUBusy, 0);
    tick();

    // MTC0 EPC in EX alongside ERET in ID.
    idle(); cpzWriteE = 1; RegAddrE = 5'd14; ERETD = 1;
    settle();
    chk("epc_fwd", Forward_EPC, 1);
    chk("eret_sel", pc_ERET, 1);
    chk("epc_nostall", Stall_PC, 0);
    RegAddrE = 5'd13;
    settle();
    chk("epc_other_reg", Forward_EPC, 0);
    tick();

    // Saturation under a long stall, then clear while still stalling.
    idle(); MemtoRegE = 1; RegAddrE = 5'd3; RtD = 5'd3;
    for (int i = 0; i < SAT + 4; i++) begin settle(); tick(); end
    settle();
    chk("sat_hold", StallCnt, SAT);
    StallCntClr = 1;
    tick();
    StallCntClr = 0;
    settle();
    chk("clr_prio", StallCnt, 0);
    tick();

    // Asynchronous reset in mid-cycle while the MDU is busy.
    idle(); MDUStartE = 1; MDUUseD = 1;
    settle(); tick();
    idle();
    reset = 1'b1;
    #1;
    busy_end = 0; sc = 0;
    chk("async_rst_cnt", StallCnt, 0);
    chk("async_rst_busy", MDUBusy, 0);
    settle(); tick();
    reset = 1'b0;

    for (int i = 0; i < 2000; i++) begin
      rand_inputs();
      settle();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
